// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter
// Round-robin arbiter that shares one combinational sprite palette among
// NUM_REQ pixel requesters. The winning index is driven to the palette in the
// same cycle. The returned RGB and the winner id are captured in a single
// registered response slot that supports backpressure.
//
// Handshake: a request transfers on a rising edge when req_valid[i] and
// req_ready[i] are both high. A response transfers when rsp_valid and
// rsp_ready are both high. req_ready never depends on req_index. Once
// rsp_valid is high, the response stays stable until rsp_ready is seen.
module palette_lookup_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [IDX_W-1:0]         pal_index,
  input  logic [COLOR_W-1:0]       pal_red,
  input  logic [COLOR_W-1:0]       pal_green,
  input  logic [COLOR_W-1:0]       pal_blue,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [COLOR_W-1:0]       rsp_red,
  output logic [COLOR_W-1:0]       rsp_green,
  output logic [COLOR_W-1:0]       rsp_blue
);

  localparam logic [ID_W:0]   NUM_REQ_C = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  // Slot state: rsp_valid_q low means EMPTY, high means FULL.
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
  logic [COLOR_W-1:0] rsp_red_q,   rsp_red_d;
  logic [COLOR_W-1:0] rsp_green_q, rsp_green_d;
  logic [COLOR_W-1:0] rsp_blue_q,  rsp_blue_d;
  logic [ID_W-1:0]    rr_ptr_q,    rr_ptr_d;

  logic               can_accept;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W:0]      cand;

  // The slot can take new data if it is empty or is being drained this cycle.
  assign can_accept = !rsp_valid_q || rsp_ready;

  // Round-robin search starting at rr_ptr, with an explicit modulo wrap.
  // This keeps a non-power-of-2 NUM_REQ correct.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    if (can_accept) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (cand >= NUM_REQ_C) cand = cand - NUM_REQ_C;
        if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
          gnt_found = 1'b1;
          gnt_id    = cand[ID_W-1:0];
        end
      end
    end
  end

  // One-hot ready to the winner, and the winner's index to the palette.
  always_comb begin
    req_ready = '0;
    pal_index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = gnt_found && (gnt_id == ID_W'(i));
    end
    if (gnt_found) pal_index = req_index[int'(gnt_id)*IDX_W +: IDX_W];
  end

  // Slot next state.
  // Accept: refill the slot, which also covers a drain in the same cycle.
  // Drain only: clear the valid flag and keep the old data.
  // Otherwise: hold the slot.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_red_d   = rsp_red_q;
    rsp_green_d = rsp_green_q;
    rsp_blue_d  = rsp_blue_q;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_found) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_red_d   = pal_red;
      rsp_green_d = pal_green;
      rsp_blue_d  = pal_blue;
      rr_ptr_d    = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset. Reset drops any held response.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_red_q   <= '0;
      rsp_green_q <= '0;
      rsp_blue_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_red_q   <= rsp_red_d;
      rsp_green_q <= rsp_green_d;
      rsp_blue_q  <= rsp_blue_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_red   = rsp_red_q;
  assign rsp_green = rsp_green_q;
  assign rsp_blue  = rsp_blue_q;

endmodule
